// File: rtl/dst_xbar.sv
// Destination-addressed crossbar: each input names its target output, and each output
// runs a round-robin arbiter feeding a one-entry output register.
module dst_xbar #(
    parameter int unsigned LINE_WIDTH = 8,
    parameter int unsigned NUM_LINES  = 6,
    localparam int unsigned IW        = $clog2(NUM_LINES)
) (
    input  logic                                  clk_i,
    input  logic                                  arst_ni,
    input  logic [NUM_LINES-1:0][LINE_WIDTH-1:0]  in_data_i,
    input  logic [NUM_LINES-1:0][IW-1:0]          in_dest_i,
    input  logic [NUM_LINES-1:0]                  in_valid_i,
    output logic [NUM_LINES-1:0]                  in_ready_o,
    output logic [NUM_LINES-1:0][LINE_WIDTH-1:0]  out_data_o,
    output logic [NUM_LINES-1:0][IW-1:0]          out_src_o,
    output logic [NUM_LINES-1:0]                  out_valid_o,
    input  logic [NUM_LINES-1:0]                  out_ready_i,
    output logic                                  dest_err_o
);

    logic [NUM_LINES-1:0][IW-1:0]        ptr_q;
    logic [NUM_LINES-1:0][NUM_LINES-1:0] gnt_c;      // [output][input]
    logic [NUM_LINES-1:0]                any_gnt_c;
    logic [NUM_LINES-1:0][IW-1:0]        win_c;
    logic [NUM_LINES-1:0]                drop_c;
    logic [NUM_LINES-1:0]                granted_c;
    logic [IW:0]                         pos_c;
    logic [IW-1:0]                       idx_c;

    // Out-of-range destinations are consumed and discarded.
    always_comb begin
        drop_c = '0;
        for (int unsigned i = 0; i < NUM_LINES; i++) begin
            drop_c[i] = ({1'b0, in_dest_i[i]} >= (IW+1)'(NUM_LINES));
        end
    end

    // Per-output round-robin search starting at ptr_q, wrapping modulo NUM_LINES.
    always_comb begin
        gnt_c     = '0;
        any_gnt_c = '0;
        win_c     = '0;
        pos_c     = '0;
        idx_c     = '0;
        for (int unsigned j = 0; j < NUM_LINES; j++) begin
            if (arst_ni && (!out_valid_o[j] || out_ready_i[j])) begin
                for (int unsigned off = 0; off < NUM_LINES; off++) begin
                    pos_c = {1'b0, ptr_q[j]} + (IW+1)'(off);
                    if (pos_c >= (IW+1)'(NUM_LINES)) begin
                        pos_c = pos_c - (IW+1)'(NUM_LINES);
                    end
                    idx_c = pos_c[IW-1:0];
                    if (!any_gnt_c[j] && in_valid_i[idx_c] && (in_dest_i[idx_c] == IW'(j))) begin
                        gnt_c[j][idx_c] = 1'b1;
                        any_gnt_c[j]    = 1'b1;
                        win_c[j]        = idx_c;
                    end
                end
            end
        end
    end

    always_comb begin
        granted_c = '0;
        for (int unsigned j = 0; j < NUM_LINES; j++) begin
            granted_c = granted_c | gnt_c[j];
        end
        in_ready_o = arst_ni ? (granted_c | drop_c) : '0;
    end

    // Output registers: a grant loads (drain and refill may share an edge), otherwise drain on ready.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            out_data_o  <= '0;
            out_src_o   <= '0;
            out_valid_o <= '0;
            ptr_q       <= '0;
            dest_err_o  <= 1'b0;
        end else begin
            for (int unsigned j = 0; j < NUM_LINES; j++) begin
                if (any_gnt_c[j]) begin
                    out_data_o[j]  <= in_data_i[win_c[j]];
                    out_src_o[j]   <= win_c[j];
                    out_valid_o[j] <= 1'b1;
                    ptr_q[j]       <= (win_c[j] == IW'(NUM_LINES-1)) ? '0 : win_c[j] + 1'b1;
                end else if (out_ready_i[j] && out_valid_o[j]) begin
                    out_valid_o[j] <= 1'b0;
                end
            end
            dest_err_o <= |(in_valid_i & drop_c);
        end
    end

endmodule

// File: tb/tb_dst_xbar.sv
// Directed bench for dst_xbar: a vector table of single-cycle cases plus hand-written
// round-robin, backpressure and mid-stream reset sequences.
module tb_dst_xbar;

    localparam int unsigned LW = 8;
    localparam int unsigned NL = 6;
    localparam int unsigned IW = 3;

    logic                   clk;
    logic                   arst_n;
    logic [NL-1:0][LW-1:0]  in_data;
    logic [NL-1:0][IW-1:0]  in_dest;
    logic [NL-1:0]          in_valid;
    logic [NL-1:0]          in_ready;
    logic [NL-1:0][LW-1:0]  out_data;
    logic [NL-1:0][IW-1:0]  out_src;
    logic [NL-1:0]          out_valid;
    logic [NL-1:0]          out_ready;
    logic                   dest_err;

    int n_vec  = 0;
    int n_miss = 0;

    dst_xbar #(.LINE_WIDTH(LW), .NUM_LINES(NL)) dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .in_data_i   (in_data),
        .in_dest_i   (in_dest),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .out_data_o  (out_data),
        .out_src_o   (out_src),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .dest_err_o  (dest_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [NL-1:0]          valid;
        logic [NL-1:0][IW-1:0]  dest;
        logic [NL-1:0][LW-1:0]  data;
        logic [NL-1:0]          ordy;
        logic [NL-1:0]          exp_rdy;
        logic [NL-1:0]          exp_ov;
        logic [NL-1:0][LW-1:0]  exp_od;
        logic [NL-1:0][IW-1:0]  exp_os;
        logic                   exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid  = '0;
        in_dest   = '0;
        in_data   = '0;
        out_ready = '1;
    endtask

    // Reset pulse; leaves the bench at posedge+1 ready to drive.
    task automatic do_reset();
        idle_inputs();
        arst_n = 1'b0;
        #1;
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v, input int k);
        in_valid  = v.valid;
        in_dest   = v.dest;
        in_data   = v.data;
        out_ready = v.ordy;
        #1;
        chk($sformatf("v%0d in_ready", k), 64'(in_ready), 64'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d out_valid", k), 64'(out_valid), 64'(v.exp_ov));
        for (int j = 0; j < NL; j++) begin
            if (v.exp_ov[j]) begin
                chk($sformatf("v%0d out_data[%0d]", k, j), 64'(out_data[j]), 64'(v.exp_od[j]));
                chk($sformatf("v%0d out_src[%0d]", k, j), 64'(out_src[j]), 64'(v.exp_os[j]));
            end
        end
        chk($sformatf("v%0d dest_err", k), 64'(dest_err), 64'(v.exp_err));
    endtask

    initial begin
        vec_t v;
        int   exp_g[6];
        arst_n = 1'b0;
        idle_inputs();

        // v0: single transfer, input 2 -> output 4
        v = '0; v.ordy = '1;
        v.valid[2] = 1'b1; v.dest[2] = 3'd4; v.data[2] = 8'hA5;
        v.exp_rdy = 6'b000100; v.exp_ov = 6'b010000; v.exp_od[4] = 8'hA5; v.exp_os[4] = 3'd2;
        vecs.push_back(v);
        // v1: idle, output 4 drains
        v = '0; v.ordy = '1;
        vecs.push_back(v);
        // v2: all inputs in parallel, input i -> output 5-i
        v = '0; v.ordy = '1; v.valid = '1; v.exp_rdy = '1; v.exp_ov = '1;
        for (int i = 0; i < NL; i++) begin
            v.dest[i]      = IW'(5 - i);
            v.data[i]      = LW'(8'h10 + i);
            v.exp_od[5-i]  = LW'(8'h10 + i);
            v.exp_os[5-i]  = IW'(i);
        end
        vecs.push_back(v);
        // v3: out-of-range dest 7 is consumed, error pulse follows
        v = '0; v.ordy = '1;
        v.valid[1] = 1'b1; v.dest[1] = 3'd7; v.data[1] = 8'hEE;
        v.exp_rdy = 6'b000010; v.exp_err = 1'b1;
        vecs.push_back(v);
        // v4: idle, error pulse lasts one cycle
        v = '0; v.ordy = '1;
        vecs.push_back(v);
        // v5: dest 6 boundary drop alongside a legal transfer 5 -> 5
        v = '0; v.ordy = '1;
        v.valid[0] = 1'b1; v.dest[0] = 3'd6; v.data[0] = 8'h66;
        v.valid[5] = 1'b1; v.dest[5] = 3'd5; v.data[5] = 8'h77;
        v.exp_rdy = 6'b100001; v.exp_ov = 6'b100000; v.exp_od[5] = 8'h77; v.exp_os[5] = 3'd5;
        v.exp_err = 1'b1;
        vecs.push_back(v);
        // v6: idle
        v = '0; v.ordy = '1;
        vecs.push_back(v);
        // v7: empty output accepts even with downstream stalled
        v = '0; v.ordy = '0;
        v.valid[3] = 1'b1; v.dest[3] = 3'd0; v.data[3] = 8'h3C;
        v.exp_rdy = 6'b001000; v.exp_ov = 6'b000001; v.exp_od[0] = 8'h3C; v.exp_os[0] = 3'd3;
        vecs.push_back(v);
        // v8: full output blocks its requester and holds
        v = '0; v.ordy = '0;
        v.valid[0] = 1'b1; v.dest[0] = 3'd0; v.data[0] = 8'h11;
        v.exp_rdy = 6'b000000; v.exp_ov = 6'b000001; v.exp_od[0] = 8'h3C; v.exp_os[0] = 3'd3;
        vecs.push_back(v);
        // v9: drain and refill on the same edge
        v.ordy = '1;
        v.exp_rdy = 6'b000001; v.exp_od[0] = 8'h11; v.exp_os[0] = 3'd0;
        vecs.push_back(v);
        // v10: idle, drains
        v = '0; v.ordy = '1;
        vecs.push_back(v);

        // reset state
        #1;
        chk("reset in_ready", 64'(in_ready), 64'd0);
        chk("reset out_valid", 64'(out_valid), 64'd0);
        chk("reset out_data", 64'(out_data), 64'd0);
        chk("reset out_src", 64'(out_src), 64'd0);
        chk("reset dest_err", 64'(dest_err), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            apply(vecs[k], k);
        end

        // Round-robin: inputs 1, 3, 5 contend for output 0
        do_reset();
        exp_g = '{1, 3, 5, 1, 3, 5};
        for (int i = 1; i < NL; i += 2) begin
            in_valid[i] = 1'b1;
            in_dest[i]  = 3'd0;
            in_data[i]  = LW'(8'hB0 + i);
        end
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("rr%0d in_ready", c), 64'(in_ready), 64'(6'b1 << exp_g[c]));
            @(posedge clk);
            #1;
            chk($sformatf("rr%0d out_src0", c), 64'(out_src[0]), 64'(exp_g[c]));
            chk($sformatf("rr%0d out_data0", c), 64'(out_data[0]), 64'(8'hB0 + exp_g[c]));
        end

        // Backpressure on output 2
        idle_inputs();
        in_valid[0] = 1'b1; in_dest[0] = 3'd2; in_data[0] = 8'h3C;
        @(posedge clk);
        #1;
        chk("bp fill", 64'({out_valid[2], out_data[2]}), 64'({1'b1, 8'h3C}));
        in_valid[0] = 1'b0;
        in_valid[4] = 1'b1; in_dest[4] = 3'd2; in_data[4] = 8'h44;
        out_ready[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp%0d in_ready4", c), 64'(in_ready[4]), 64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d hold", c), 64'({out_valid[2], out_data[2]}), 64'({1'b1, 8'h3C}));
        end
        out_ready[2] = 1'b1;
        #1;
        chk("bp release in_ready4", 64'(in_ready[4]), 64'd1);
        @(posedge clk);
        #1;
        chk("bp refill", 64'({out_valid[2], out_data[2], out_src[2]}), 64'({1'b1, 8'h44, 3'd4}));

        // Reset mid-stream with output 2 still full
        idle_inputs();
        out_ready[2] = 1'b0;
        in_valid[0] = 1'b1;
        #2;
        arst_n = 1'b0;
        #1;
        chk("midrst out_valid", 64'(out_valid), 64'd0);
        chk("midrst in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        out_ready = '1;
        in_valid = 6'b001001; in_dest = '0;
        in_data[0] = 8'hA0; in_data[3] = 8'hA3;
        #1;
        chk("postrst in_ready", 64'(in_ready), 64'(6'b000001));
        @(posedge clk);
        #1;
        chk("postrst grant0", 64'({out_src[0], out_data[0]}), 64'({3'd0, 8'hA0}));
        #1;
        chk("postrst in_ready2", 64'(in_ready), 64'(6'b001000));
        @(posedge clk);
        #1;
        chk("postrst grant3", 64'({out_src[0], out_data[0]}), 64'({3'd3, 8'hA3}));
        idle_inputs();
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/dst_xbar.md
# dst_xbar

Destination-addressed crossbar switch with valid/ready handshakes. Each of NUM_LINES input ports presents a beat together with the index of the output it wants to reach. Each output port runs its own round-robin arbiter over the inputs that target it, and holds the winning beat in a one-entry output register. The switch is the transmit-side counterpart of the select-addressed crossbar: sources choose their destination, and contention is resolved in hardware.

## Interface
- LINE_WIDTH, 8, data bits per beat
- NUM_LINES, 6, number of input ports and number of output ports (≥2); IW = $clog2(NUM_LINES)
- clk_i  input  1  clock; all logic is on the rising edge
- arst_ni  input  1  reset, asynchronous and active-low
- in_data_i  input  [NUM_LINES][LINE_WIDTH]  beat payload per input
- in_dest_i  input  [NUM_LINES][IW]  target output index per input
- in_valid_i  input  [NUM_LINES]  input beat valid
- in_ready_o  output  [NUM_LINES]  input beat accepted this cycle
- out_data_o  output  [NUM_LINES][LINE_WIDTH]  registered payload per output
- out_src_o  output  [NUM_LINES][IW]  index of the input that sourced the beat
- out_valid_o  output  [NUM_LINES]  output register holds a beat
- out_ready_i  input  [NUM_LINES]  downstream accepts output beat
- dest_err_o  output  1  registered one-cycle pulse: at least one beat was dropped for an out-of-range destination in the previous cycle

## Operation
- Handshake: a transfer occurs when valid and ready are both high at a rising edge.
  - While valid is high and ready is low, the source holds valid, data and dest stable.
  - An output holds out_data_o/out_src_o stable while out_valid_o=1 and out_ready_i=0.
- Per output j:
  - req_j[i] = in_valid_i[i] && in_dest_i[i]==j.
  - free_j = !out_valid_o[j] || out_ready_i[j].
  - If free_j and req_j is non-zero, the arbiter grants exactly one input k. The search starts at ptr_j and wraps modulo NUM_LINES.
- in_ready_o[i] = 1 when input i is granted by its target output, or when in_dest_i[i] ≥ NUM_LINES (drop case). Otherwise it is 0.
  - in_ready_o is combinational from in_valid_i, in_dest_i, out_ready_i and internal state. No combinational path exists from in_ready_o back to any input.
- On a grant to k at output j, the next state is:
  - out_data_o[j] ← in_data_i[k]
  - out_src_o[j] ← k
  - out_valid_o[j] ← 1
  - ptr_j ← (k+1) mod NUM_LINES
- Without a grant:
  - If out_ready_i[j] && out_valid_o[j], then out_valid_o[j] ← 0.
  - Otherwise the output register holds.
  - ptr_j is unchanged.
- Drop case: a valid beat with in_dest_i ≥ NUM_LINES (possible only when NUM_LINES is not a power of 2) is consumed and discarded. dest_err_o is high on the next cycle.
- Fairness: a continuously requesting input is granted within NUM_LINES-1 grants of its target output.
- Outputs are independent: different inputs targeting different outputs all transfer in the same cycle.

## Timing
- Reset (arst_ni low, applied asynchronously):
  - out_valid_o=0, out_data_o=0, out_src_o=0, dest_err_o=0, all ptr_j=0.
  - in_ready_o is 0 while in reset.
- Latency: an input beat accepted at edge n appears on out_valid_o/out_data_o after edge n, i.e. 1 cycle.
- Throughput: with out_ready_i[j]=1 constantly, output j accepts one beat per cycle (full rate). Same-cycle drain and refill is allowed.
- Output full (out_valid_o[j]=1, out_ready_i[j]=0): no grant at j, and every input targeting j sees in_ready_o=0.
- Reset mid-operation: any beats held in output registers are lost. Pointers return to 0. The first grant after reset follows priority order starting at input 0.
- Requester set changing while not granted (source withdrawing valid, which violates protocol) produces no transfer; no state changes.

## Test plan
- Single transfer: reset, then input 2 sends 0xA5 to dest 4 with out_ready_i=all 1 → in_ready_o[2]=1 in that cycle. Next cycle out_valid_o[4]=1, out_data_o[4]=0xA5, out_src_o[4]=2. All other out_valid_o are 0.
- Parallel: inputs 0..5 send 0x10+i to dest (5-i) in one cycle → all in_ready_o=1. Next cycle every output j shows data 0x10+(5-j) and src 5-j.
- Round-robin contention: after reset, inputs 1, 3 and 5 hold valid to dest 0 with out_ready_i[0]=1 → grant order is 1, 3, 5, 1, 3, 5 on consecutive cycles. out_src_o[0] follows that sequence one cycle later.
- Backpressure: output 2 is filled with 0x3C and out_ready_i[2]=0 for 5 cycles while input 4 requests dest 2.
  - During those cycles, in_ready_o[4]=0 and out_data_o[2] stays 0x3C.
  - When ready rises, the drain and the refill with input 4's beat happen on the same edge.
- Reset mid-stream: assert arst_ni low between edges while outputs are valid → out_valid_o goes to 0 immediately. After release, contention from inputs 0 and 3 is granted to 0 first.
- Out-of-range: with NUM_LINES=6, input 1 sends dest 7 → in_ready_o[1]=1. No out_valid_o rises, and dest_err_o=1 for exactly the next cycle.
